// File: rtl/rx_counter_checker.sv
// RX loopback checker: bit-aligns an incrementing counter stream, locks, counts errors.
// Optional first-error capture enabled with RX_CHK_ERR_LOG_EN.
module rx_counter_checker #(
  parameter int LOCK_CNT = 16,
  parameter int SETTLE   = 4,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic [7:0]       aligned_data,
  output logic             aligned_valid,
  output logic [2:0]       slip,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      word_cnt,
  output logic             slip_wrap
`ifdef RX_CHK_ERR_LOG_EN
  ,
  output logic [7:0]       first_err_exp,
  output logic [7:0]       first_err_got,
  output logic [31:0]      first_err_word,
  output logic             first_err_vld
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SETTLE,
    S_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       prev_raw_q, prev_raw_d;
  logic [7:0]       aligned_data_q, aligned_data_d;
  logic             aligned_valid_q, aligned_valid_d;
  logic [2:0]       slip_q, slip_d;
  logic             prime_q, prime_d;
  logic [7:0]       ref_q, ref_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [LW-1:0]    miss_run_q, miss_run_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic             slip_wrap_q, slip_wrap_d;
  logic [15:0]      cat;
  logic             match;
`ifdef RX_CHK_ERR_LOG_EN
  logic [7:0]       fe_exp_q, fe_exp_d;
  logic [7:0]       fe_got_q, fe_got_d;
  logic [31:0]      fe_word_q, fe_word_d;
  logic             fe_vld_q, fe_vld_d;
`endif

  assign cat   = {data_in, prev_raw_q};
  assign match = (aligned_data_q == ref_q + 8'd1);

  always_comb begin
    state_d         = state_q;
    prev_raw_d      = prev_raw_q;
    aligned_data_d  = aligned_data_q;
    aligned_valid_d = data_valid;
    slip_d          = slip_q;
    prime_d         = prime_q;
    ref_d           = ref_q;
    match_cnt_d     = match_cnt_q;
    settle_cnt_d    = settle_cnt_q;
    miss_run_d      = miss_run_q;
    err_pulse_d     = 1'b0;
    err_cnt_d       = err_cnt_q;
    word_cnt_d      = word_cnt_q;
    slip_wrap_d     = slip_wrap_q;
`ifdef RX_CHK_ERR_LOG_EN
    fe_exp_d        = fe_exp_q;
    fe_got_d        = fe_got_q;
    fe_word_d       = fe_word_q;
    fe_vld_d        = fe_vld_q;
`endif
    if (data_valid) begin
      prev_raw_d     = data_in;
      aligned_data_d = cat[{1'b0, slip_q} +: 8];
    end
    // FSM consumes the registered word only
    if (aligned_valid_q) begin
      unique case (state_q)
        S_SEARCH: begin
          if (!prime_q) begin
            ref_d   = aligned_data_q;
            prime_d = 1'b1;
          end else if (match) begin
            ref_d = aligned_data_q;
            if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
              state_d     = S_LOCKED;
              match_cnt_d = '0;
              miss_run_d  = '0;
            end else begin
              match_cnt_d = match_cnt_q + MW'(1);
            end
          end else begin
            slip_d       = slip_q + 3'd1;
            slip_wrap_d  = slip_wrap_q | (slip_q == 3'd7);
            match_cnt_d  = '0;
            settle_cnt_d = '0;
            prime_d      = 1'b0;
            state_d      = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == SW'(SETTLE - 1)) begin
            settle_cnt_d = '0;
            prime_d      = 1'b0;
            state_d      = S_SEARCH;
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end
        end
        S_LOCKED: begin
          if (match) begin
            word_cnt_d = word_cnt_q + 32'd1;
            miss_run_d = '0;
            ref_d      = aligned_data_q;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            ref_d = ref_q + 8'd1;
`ifdef RX_CHK_ERR_LOG_EN
            if (!fe_vld_q) begin
              fe_vld_d  = 1'b1;
              fe_exp_d  = ref_q + 8'd1;
              fe_got_d  = aligned_data_q;
              fe_word_d = word_cnt_q;
            end
`endif
            if (miss_run_q == LW'(LOSS_CNT - 1)) begin
              miss_run_d  = '0;
              match_cnt_d = '0;
              prime_d     = 1'b0;
              state_d     = S_SEARCH;
            end else begin
              miss_run_d = miss_run_q + LW'(1);
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_SEARCH;
      prev_raw_q      <= '0;
      aligned_data_q  <= '0;
      aligned_valid_q <= 1'b0;
      slip_q          <= '0;
      prime_q         <= 1'b0;
      ref_q           <= '0;
      match_cnt_q     <= '0;
      settle_cnt_q    <= '0;
      miss_run_q      <= '0;
      err_pulse_q     <= 1'b0;
      err_cnt_q       <= '0;
      word_cnt_q      <= '0;
      slip_wrap_q     <= 1'b0;
`ifdef RX_CHK_ERR_LOG_EN
      fe_exp_q        <= '0;
      fe_got_q        <= '0;
      fe_word_q       <= '0;
      fe_vld_q        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      prev_raw_q      <= prev_raw_d;
      aligned_data_q  <= aligned_data_d;
      aligned_valid_q <= aligned_valid_d;
      slip_q          <= slip_d;
      prime_q         <= prime_d;
      ref_q           <= ref_d;
      match_cnt_q     <= match_cnt_d;
      settle_cnt_q    <= settle_cnt_d;
      miss_run_q      <= miss_run_d;
      err_pulse_q     <= err_pulse_d;
      err_cnt_q       <= err_cnt_d;
      word_cnt_q      <= word_cnt_d;
      slip_wrap_q     <= slip_wrap_d;
`ifdef RX_CHK_ERR_LOG_EN
      fe_exp_q        <= fe_exp_d;
      fe_got_q        <= fe_got_d;
      fe_word_q       <= fe_word_d;
      fe_vld_q        <= fe_vld_d;
`endif
    end
  end

  assign aligned_data  = aligned_data_q;
  assign aligned_valid = aligned_valid_q;
  assign slip          = slip_q;
  assign locked        = (state_q == S_LOCKED);
  assign err_pulse     = err_pulse_q;
  assign err_cnt       = err_cnt_q;
  assign word_cnt      = word_cnt_q;
  assign slip_wrap     = slip_wrap_q;
`ifdef RX_CHK_ERR_LOG_EN
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;
  assign first_err_word = fe_word_q;
  assign first_err_vld  = fe_vld_q;
`endif

endmodule

// File: tb/tb_rx_counter_checker.sv
// Directed bench for rx_counter_checker: lock, errors, loss/relock,
// gaps, reset, slip wrap and a 3-bit delayed stream.
module tb_rx_counter_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [7:0]  aligned_data;
  logic        aligned_valid;
  logic [2:0]  slip;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
  logic        slip_wrap;
`ifdef RX_CHK_ERR_LOG_EN
  logic [7:0]  first_err_exp;
  logic [7:0]  first_err_got;
  logic [31:0] first_err_word;
  logic        first_err_vld;
`endif

  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0]  c, pc, a0;
  logic [15:0] w16;

  rx_counter_checker dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .aligned_data (aligned_data),
    .aligned_valid(aligned_valid),
    .slip         (slip),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_cnt      (err_cnt),
    .word_cnt     (word_cnt),
    .slip_wrap    (slip_wrap)
`ifdef RX_CHK_ERR_LOG_EN
    ,
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got),
    .first_err_word(first_err_word),
    .first_err_vld (first_err_vld)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic v);
    data_in    = d;
    data_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_locked", locked, 0);
    chk("rst_slip", slip, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_avalid", aligned_valid, 0);
    chk("rst_epulse", err_pulse, 0);
    chk("rst_wrap", slip_wrap, 0);

    // aligned counter at slip 0
    for (int i = 1; i <= 17; i++) push(8'(i), 1'b1);
    chk("t1_not_yet", locked, 0);
    push(8'd18, 1'b1);
    chk("t1_locked", locked, 1);
    chk("t1_slip", slip, 0);
    for (int i = 19; i <= 300; i++) push(8'(i), 1'b1);
    chk("t1_word_cnt", word_cnt, 282);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_adata", aligned_data, 8'h2B);
    chk("t1_still_locked", locked, 1);

    // single corrupted word 0x5A in place of 0x40
    for (int i = 301; i <= 319; i++) push(8'(i), 1'b1);
    push(8'h5A, 1'b1);
    push(8'h41, 1'b1);
    chk("t3_no_pulse_yet", err_pulse, 0);
    push(8'h42, 1'b1);
    chk("t3_pulse", err_pulse, 1);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_locked", locked, 1);
    push(8'h43, 1'b1);
    chk("t3_pulse_gone", err_pulse, 0);
    chk("t3_word_cnt", word_cnt, 304);
    chk("t3_err_cnt2", err_cnt, 1);

    // four garbage words force loss of lock
    for (int i = 324; i <= 329; i++) push(8'(i), 1'b1);
    push(8'hAA, 1'b1);
    push(8'h13, 1'b1);
    push(8'hC7, 1'b1);
    push(8'h00, 1'b1);
    push(8'(334), 1'b1);
    chk("t4_locked_3miss", locked, 1);
    chk("t4_err_3miss", err_cnt, 4);
    push(8'(335), 1'b1);
    chk("t4_lost", locked, 0);
    chk("t4_err_cnt", err_cnt, 5);
    chk("t4_slip", slip, 0);
    chk("t4_word_kept", word_cnt, 312);
    for (int i = 336; i <= 351; i++) push(8'(i), 1'b1);
    chk("t4_not_relocked", locked, 0);
    push(8'(352), 1'b1);
    chk("t4_relocked", locked, 1);
    chk("t4_slip2", slip, 0);
    chk("t4_err_kept", err_cnt, 5);
    chk("t4_word_cnt", word_cnt, 312);

    // data_valid toggling while locked
    for (int k = 0; k < 20; k++) begin
      push(8'(353 + k), 1'b1);
      chk("t5_avalid_hi", aligned_valid, 1);
      chk("t5_adata", aligned_data, 8'(352 + k));
      push(8'hEE, 1'b0);
      chk("t5_avalid_lo", aligned_valid, 0);
    end
    chk("t5_word_cnt", word_cnt, 333);
    chk("t5_err_cnt", err_cnt, 5);
    chk("t5_locked", locked, 1);

    // reset while locked
    do_reset();
    chk("t6_locked", locked, 0);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_word_cnt", word_cnt, 0);
    chk("t6_slip", slip, 0);
    chk("t6_avalid", aligned_valid, 0);
    for (int i = 1; i <= 17; i++) push(8'(i), 1'b1);
    chk("t6_not_yet", locked, 0);
    push(8'd18, 1'b1);
    chk("t6_relocked", locked, 1);
    chk("t6_err_after", err_cnt, 0);

    // constant stream never locks and wraps the slip
    do_reset();
    chk("tw_wrap_clr", slip_wrap, 0);
    for (int i = 0; i < 60; i++) push(8'h00, 1'b1);
    chk("tw_wrap_set", slip_wrap, 1);
    chk("tw_locked", locked, 0);

    // counter bit stream delayed by 3 bits
    do_reset();
    n  = 0;
    pc = 8'h00;
    while (locked !== 1'b1 && n < 80) begin
      c   = 8'(n);
      w16 = {c, pc};
      push(w16[12:5], 1'b1);
      pc = c;
      n++;
    end
    chk("t2_lock_bound", 32'(n <= 66), 1);
    chk("t2_locked", locked, 1);
    chk("t2_slip", slip, 3);
    a0  = aligned_data;
    c   = 8'(n);
    w16 = {c, pc};
    push(w16[12:5], 1'b1);
    pc = c;
    n++;
    chk("t2_incr", aligned_data, 8'(a0 + 8'd1));
    a0  = aligned_data;
    c   = 8'(n);
    w16 = {c, pc};
    push(w16[12:5], 1'b1);
    chk("t2_incr2", aligned_data, 8'(a0 + 8'd1));
    chk("t2_err_cnt", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
